// File: rtl/morse_key_sequencer.sv
// Morse key front end: times key presses into dot/dash/end-of-char symbols and strobes them
// to the decoder. Optional debouncer enabled with `define KEY_DEBOUNCE_EN.
module morse_key_sequencer #(
  parameter int TICK_DIV       = 25000,
  parameter int DOT_MAX_TICKS  = 15,
  parameter int CHAR_GAP_TICKS = 45,
  parameter int MAX_SYMBOLS    = 5,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic       recieve,
  output logic [1:0] datain,
  output logic [2:0] sym_count,
  output logic       key_held
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] DOT_LIM   = CNT_W'(DOT_MAX_TICKS);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(CHAR_GAP_TICKS);
  localparam logic [2:0]       SYM_LIM   = 3'(MAX_SYMBOLS);

  typedef enum logic [2:0] {S_IDLE, S_PRESS, S_GAP, S_SETUP, S_STROBE, S_HOLD} state_t;
  typedef enum logic [1:0] {SYM_EOC = 2'd0, SYM_DOT = 2'd1, SYM_DASH = 2'd2} sym_t;

  logic             r_sync1, r_sync2, r_key_prev, r_armed;
  logic [1:0]       r_fill;
  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_press_cnt, r_gap_cnt;
  logic [2:0]       r_sym_count;
  state_t           r_state, w_next;
  sym_t             r_datain, w_sym;
  logic             w_tick, w_key, w_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
      r_key_prev <= 1'b0;
      r_presc    <= '0;
    end else begin
      r_sync1    <= key_in;
      r_sync2    <= r_sync1;
      r_fill     <= {r_fill[0], 1'b1};
      // A press still held across reset is not a new press: wait for a real release first.
      if (r_fill == 2'b11 && !r_sync2 && !w_key) r_armed <= 1'b1;
      r_key_prev <= w_key;
      r_presc    <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

`ifdef KEY_DEBOUNCE_EN
  logic r_db_level, r_db_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_level <= 1'b0;
      r_db_seen  <= 1'b0;
    end else if (r_sync2 == r_db_level) begin
      r_db_seen <= 1'b0;
    end else if (w_tick) begin
      if (r_db_seen) begin
        r_db_level <= r_sync2;
        r_db_seen  <= 1'b0;
      end else begin
        r_db_seen <= 1'b1;
      end
    end
  end

  assign w_key = r_db_level;
`else
  assign w_key = r_sync2;
`endif

  assign w_rise   = w_key & ~r_key_prev;
  assign key_held = w_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (w_rise)                                 r_press_cnt <= '0;
      else if (w_tick && r_press_cnt != CNT_MAX)  r_press_cnt <= r_press_cnt + 1'b1;
      if (r_state != S_GAP || w_rise)             r_gap_cnt   <= '0;
      else if (w_tick && r_gap_cnt != CNT_MAX)    r_gap_cnt   <= r_gap_cnt + 1'b1;
    end
  end

  // NOTE: defaults first so every path assigns w_next/w_sym and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_sym  = r_datain;
    case (r_state)
      S_IDLE:   if (r_armed && w_key) w_next = S_PRESS;
      S_PRESS: begin
        if (!w_key) begin
          if (r_press_cnt == '0) begin
            w_next = (r_sym_count != 3'd0) ? S_GAP : S_IDLE;
          end else begin
            w_sym  = (r_press_cnt < DOT_LIM) ? SYM_DOT : SYM_DASH;
            w_next = S_SETUP;
          end
        end
      end
      S_GAP: begin
        if (w_key) begin
          w_next = S_PRESS;
        end else if (r_gap_cnt >= GAP_LIM) begin
          w_sym  = SYM_EOC;
          w_next = S_SETUP;
        end
      end
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: w_next = S_HOLD;
      S_HOLD: begin
        if (r_datain != SYM_EOC) begin
          if (r_sym_count + 3'd1 == SYM_LIM) begin
            w_sym  = SYM_EOC;
            w_next = S_SETUP;
          end else begin
            w_next = w_key ? S_PRESS : S_GAP;
          end
        end else begin
          w_next = w_key ? S_PRESS : S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_datain    <= SYM_EOC;
      r_sym_count <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_SETUP) r_datain <= w_sym;
      if (r_state == S_HOLD)
        r_sym_count <= (r_datain == SYM_EOC) ? 3'd0 : r_sym_count + 3'd1;
    end
  end

  assign recieve   = (r_state == S_STROBE);
  assign datain    = r_datain;
  assign sym_count = r_sym_count;

endmodule
